// File: rtl/sincos_phase_gen_pkg.sv
// Shared constants and state encoding for the NCO phase front end and sincos_quadratic.
package sincos_phase_gen_pkg;

    localparam int PHASE_W_DEF = 47;
    localparam int CNT_W_DEF   = 16;
    localparam int RESULT_W    = 56;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sincos_phase_gen_if.sv
// Config/control inputs and phase sample outputs of sincos_phase_gen; master drives config, slave is the generator.
interface sincos_phase_gen_if
    import sincos_phase_gen_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
);
    logic               load_i;
    logic [PHASE_W-1:0] ftw_i;
    logic [PHASE_W-1:0] offset_i;
    logic [PHASE_W-1:0] step_i;
    logic               sweep_en_i;
    logic [CNT_W-1:0]   burst_len_i;
    logic               start_i;
    logic               stop_i;
    logic [PHASE_W-1:0] phase_o;
    logic               valid_o;
    logic               wrap_o;
    logic               busy_o;

    modport master (
        output load_i, ftw_i, offset_i, step_i, sweep_en_i, burst_len_i, start_i, stop_i,
        input  phase_o, valid_o, wrap_o, busy_o
    );

    modport slave (
        input  load_i, ftw_i, offset_i, step_i, sweep_en_i, burst_len_i, start_i, stop_i,
        output phase_o, valid_o, wrap_o, busy_o
    );
endinterface

// File: rtl/sincos_phase_acc.sv
// Phase accumulator with chirp adder, carry-out wrap flag and offset output register; one-cycle latency.
// No backpressure: every clear/advance strobe produces one registered sample.
module sincos_phase_acc
    import sincos_phase_gen_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               advance_i,
    input  logic               load_ftw_i,
    input  logic [PHASE_W-1:0] ftw_i,
    input  logic [PHASE_W-1:0] offset_i,
    input  logic [PHASE_W-1:0] step_i,
    input  logic               sweep_en_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic               valid_o,
    output logic               wrap_o
);
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] ftw_act_q, ftw_act_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic [PHASE_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, ftw_act_q};

    always_comb begin
        acc_d     = acc_q;
        ftw_act_d = ftw_act_q;
        phase_d   = phase_q;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        if (clear_i) begin
            acc_d     = '0;
            ftw_act_d = ftw_i;
            phase_d   = offset_i;
            valid_d   = 1'b1;
        end else if (advance_i) begin
            acc_d   = sum[PHASE_W-1:0];
            phase_d = sum[PHASE_W-1:0] + offset_i;
            valid_d = 1'b1;
            wrap_d  = sum[PHASE_W];
            // A reload replaces the running FTW outright; that cycle's sweep step is dropped.
            if (load_ftw_i) begin
                ftw_act_d = ftw_i;
            end else if (sweep_en_i) begin
                ftw_act_d = ftw_act_q + step_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            ftw_act_q <= '0;
            phase_q   <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ftw_act_q <= ftw_act_d;
            phase_q   <= phase_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
        end
    end

    assign phase_o = phase_q;
    assign valid_o = valid_q;
    assign wrap_o  = wrap_q;
endmodule

// File: rtl/sincos_phase_gen.sv
// NCO phase front end: config regs, IDLE/RUN FSM and burst counter; first sample one cycle after start_i.
// No backpressure: one sample per cycle while running, the sink always accepts.
module sincos_phase_gen
    import sincos_phase_gen_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    sincos_phase_gen_if.slave  pg_if
);
    state_t             state_q, state_d;
    logic [PHASE_W-1:0] cfg_ftw_q, cfg_offset_q, cfg_step_q;
    logic [CNT_W-1:0]   cfg_len_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W:0]     count_inc;
    logic               burst_done;
    logic               clear, advance;
    logic [PHASE_W-1:0] acc_ftw, acc_offset;

    // count_q is the index of the last emitted sample in the current burst.
    assign count_inc  = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    assign burst_done = (cfg_len_q != '0) && (count_inc >= {1'b0, cfg_len_q});

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        clear   = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pg_if.start_i && !pg_if.stop_i) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                    count_d = '0;
                end
            end
            ST_RUN: begin
                if (pg_if.stop_i) begin
                    state_d = ST_IDLE;
                end else if (pg_if.start_i) begin
                    clear   = 1'b1;
                    count_d = '0;
                end else if (burst_done) begin
                    state_d = ST_IDLE;
                end else begin
                    advance = 1'b1;
                    count_d = count_inc[CNT_W-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_ftw_q    <= '0;
            cfg_offset_q <= '0;
            cfg_step_q   <= '0;
            cfg_len_q    <= '0;
        end else if (pg_if.load_i) begin
            cfg_ftw_q    <= pg_if.ftw_i;
            cfg_offset_q <= pg_if.offset_i;
            cfg_step_q   <= pg_if.step_i;
            cfg_len_q    <= pg_if.burst_len_i;
        end
    end

    // A load coinciding with start feeds the new values straight into sample 0.
    assign acc_ftw    = pg_if.load_i ? pg_if.ftw_i : cfg_ftw_q;
    assign acc_offset = (clear && pg_if.load_i) ? pg_if.offset_i : cfg_offset_q;

    sincos_phase_acc #(
        .PHASE_W (PHASE_W)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (clear),
        .advance_i  (advance),
        .load_ftw_i (pg_if.load_i),
        .ftw_i      (acc_ftw),
        .offset_i   (acc_offset),
        .step_i     (cfg_step_q),
        .sweep_en_i (pg_if.sweep_en_i),
        .phase_o    (pg_if.phase_o),
        .valid_o    (pg_if.valid_o),
        .wrap_o     (pg_if.wrap_o)
    );

    assign pg_if.busy_o = (state_q == ST_RUN);
endmodule

// File: tb/tb_sincos_phase_gen.sv
// Bench for sincos_phase_gen: sample-level reference model feeds expectation queues, a negedge monitor checks them.
module tb_sincos_phase_gen;
    localparam int PW = 47;
    localparam int CW = 16;

    typedef struct { bit valid; bit busy; } cyc_t;
    typedef struct { logic [PW-1:0] phase; bit wrap; } samp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sincos_phase_gen_if bus ();

    sincos_phase_gen dut (
        .clk   (clk),
        .reset (reset),
        .pg_if (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    cyc_t          cyc_q [$];
    samp_t         samp_q [$];
    logic [PW-1:0] cap_q [$];
    logic [PW-1:0] exp_caps [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference model: sample index, accumulator and active FTW tracked as plain numbers.
    logic [PW-1:0] m_acc, m_ftw, c_ftw, c_off, c_step;
    int unsigned   c_len;
    int unsigned   m_n;
    bit            m_run;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc = '0; m_ftw = '0; c_ftw = '0; c_off = '0; c_step = '0;
            c_len = 0; m_n = 0; m_run = 0;
            cyc_q.delete();
            samp_q.delete();
        end else begin
            logic [PW:0]   s;
            logic [PW-1:0] ph;
            bit            emit;
            bit            w;
            emit = 0; w = 0; ph = '0; s = '0;
            if (bus.stop_i) begin
                m_run = 0;
            end else if (bus.start_i) begin
                m_run = 1;
                m_acc = '0;
                m_ftw = bus.load_i ? bus.ftw_i : c_ftw;
                ph    = bus.load_i ? bus.offset_i : c_off;
                m_n   = 1;
                emit  = 1;
            end else if (m_run) begin
                if (c_len != 0 && m_n >= c_len) begin
                    m_run = 0;
                end else begin
                    s     = {1'b0, m_acc} + {1'b0, m_ftw};
                    w     = s[PW];
                    m_acc = s[PW-1:0];
                    ph    = m_acc + c_off;
                    if (bus.load_i) m_ftw = bus.ftw_i;
                    else if (bus.sweep_en_i) m_ftw = m_ftw + c_step;
                    m_n++;
                    emit = 1;
                end
            end
            if (bus.load_i) begin
                c_ftw = bus.ftw_i; c_off = bus.offset_i; c_step = bus.step_i;
                c_len = bus.burst_len_i;
            end
            cyc_q.push_back('{valid: emit, busy: m_run});
            if (emit) samp_q.push_back('{phase: ph, wrap: w});
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (cyc_q.size() != 0) begin
                cyc_t e;
                e = cyc_q.pop_front();
                chk("valid_o", {63'd0, bus.valid_o}, {63'd0, e.valid});
                chk("busy_o", {63'd0, bus.busy_o}, {63'd0, e.busy});
            end
            if (bus.valid_o === 1'b1) begin
                if (samp_q.size() == 0) begin
                    chk("valid_unexpected", {63'd0, bus.valid_o}, 64'd0);
                end else begin
                    samp_t sm;
                    sm = samp_q.pop_front();
                    chk("phase_o", {17'd0, bus.phase_o}, {17'd0, sm.phase});
                    chk("wrap_o", {63'd0, bus.wrap_o}, {63'd0, sm.wrap});
                end
                cap_q.push_back(bus.phase_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.load_i  = 1'b0;
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [PW-1:0] f, input logic [PW-1:0] o,
                           input logic [PW-1:0] st, input logic [CW-1:0] len);
        bus.load_i = 1'b1; bus.ftw_i = f; bus.offset_i = o; bus.step_i = st; bus.burst_len_i = len;
    endtask

    task automatic check_caps(input string name);
        chk({name, "_count"}, 64'(cap_q.size()), 64'(exp_caps.size()));
        for (int i = 0; i < exp_caps.size() && i < cap_q.size(); i++)
            chk(name, {17'd0, cap_q[i]}, {17'd0, exp_caps[i]});
        cap_q.delete();
    endtask

    initial begin
        bus.load_i = 0; bus.ftw_i = '0; bus.offset_i = '0; bus.step_i = '0;
        bus.sweep_en_i = 0; bus.burst_len_i = '0; bus.start_i = 0; bus.stop_i = 0;
        ticks(3);
        chk("rst_phase", {17'd0, bus.phase_o}, 64'd0);
        chk("rst_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("rst_wrap", {63'd0, bus.wrap_o}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
        reset = 1'b0;
        ticks(2);

        // Counted burst of four unit steps.
        do_load(47'd1, 47'd0, 47'd0, 16'd4); tick();
        cap_q.delete();
        bus.start_i = 1; tick();
        ticks(6);
        exp_caps = '{47'd0, 47'd1, 47'd2, 47'd3};
        check_caps("burst4");
        chk("burst4_busy_end", {63'd0, bus.busy_o}, 64'd0);

        // Half-range FTW wraps every second sample; stop ends output next cycle.
        do_load(47'h400000000000, 47'd5, 47'd0, 16'd0); bus.start_i = 1; tick();
        ticks(5);
        bus.stop_i = 1; tick();
        chk("stop_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("stop_busy", {63'd0, bus.busy_o}, 64'd0);
        ticks(2);
        exp_caps = '{47'd5, 47'h400000000005, 47'd5, 47'h400000000005, 47'd5, 47'h400000000005};
        check_caps("wrap_seq");

        // Downward chirp.
        bus.sweep_en_i = 1;
        do_load(47'd10, 47'd0, {PW{1'b1}}, 16'd5); tick();
        bus.start_i = 1; tick();
        ticks(6);
        exp_caps = '{47'd0, 47'd10, 47'd19, 47'd27, 47'd34};
        check_caps("sweep");
        bus.sweep_en_i = 0;

        // start+stop together in RUN, then restart mid-burst.
        do_load(47'd1, 47'd0, 47'd0, 16'd0); bus.start_i = 1; tick();
        ticks(3);
        bus.start_i = 1; bus.stop_i = 1; tick();
        chk("startstop_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("startstop_valid", {63'd0, bus.valid_o}, 64'd0);
        do_load(47'd1, 47'd0, 47'd0, 16'd4); tick();
        cap_q.delete();
        bus.start_i = 1; tick();
        ticks(2);
        bus.start_i = 1; tick();
        ticks(6);
        exp_caps = '{47'd0, 47'd1, 47'd2, 47'd0, 47'd1, 47'd2, 47'd3};
        check_caps("restart");

        // FTW reload while running leaves the accumulator alone.
        do_load(47'd1, 47'd0, 47'd0, 16'd0); tick();
        cap_q.delete();
        bus.start_i = 1; tick();
        ticks(6);
        do_load(47'd3, 47'd0, 47'd0, 16'd0); tick();
        ticks(2);
        bus.stop_i = 1; tick();
        ticks(1);
        exp_caps = '{47'd0, 47'd1, 47'd2, 47'd3, 47'd4, 47'd5, 47'd6, 47'd7, 47'd10, 47'd13};
        check_caps("reload");

        // Asynchronous reset mid-burst.
        do_load(47'd7, 47'd2, 47'd0, 16'd0); bus.start_i = 1; tick();
        ticks(4);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("arst_phase", {17'd0, bus.phase_o}, 64'd0);
        chk("arst_valid", {63'd0, bus.valid_o}, 64'd0);
        chk("arst_busy", {63'd0, bus.busy_o}, 64'd0);
        ticks(2);
        reset = 1'b0;
        ticks(5);
        chk("post_rst_valid", {63'd0, bus.valid_o}, 64'd0);
        bus.start_i = 1; tick();
        ticks(3);
        bus.stop_i = 1; tick();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            bus.sweep_en_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 6) begin
                logic [63:0] r;
                int          s;
                r = {$urandom, $urandom};
                s = $urandom_range(0, 16) - 8;
                bus.load_i      = 1'b1;
                bus.ftw_i       = ($urandom_range(0, 1) != 0) ? r[PW-1:0] : 47'($urandom_range(0, 1000));
                bus.step_i      = 47'(s);
                bus.burst_len_i = 16'($urandom_range(0, 8));
                if (!m_run) begin
                    r = {$urandom, $urandom};
                    bus.offset_i = r[PW-1:0];
                end
            end
            bus.start_i = ($urandom_range(0, 99) < 5);
            bus.stop_i  = ($urandom_range(0, 99) < 3);
            tick();
        end
        bus.stop_i = 1; tick();
        ticks(2);
        @(negedge clk); #1;
        chk("samp_q_drained", 64'(samp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
